// File: rtl/par_seri_buf.sv
// par_seri_buf: parametrised parallel-to-serial converter with a one-word holding buffer
module par_seri_buf #(
    parameter int W         = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_SO   = 1'b0
) (
    input  logic         ck,
    input  logic         rst,
    input  logic         en,
    input  logic         pv,
    input  logic [W-1:0] pi,
    output logic         pr,
    output logic         so,
    output logic         sv,
    output logic         sf,
    output logic         busy
);
    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t state, state_nx;
    logic [W-1:0] hold, sh;
    logic [CW-1:0] cnt;
    logic hold_full, load, adv, last;

    // state register
    always_ff @(posedge ck or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end

    // next state plus the load/advance strobes for the datapath
    always_comb begin
        last = state == SHIFT && en && cnt == LAST;
        load = (state == IDLE && hold_full) || (last && hold_full);
        adv = state == SHIFT && en && cnt != LAST;
        state_nx = state;
        if (state == IDLE && hold_full) state_nx = SHIFT;
        else if (last && !hold_full) state_nx = IDLE;
    end

    // holding buffer, shifter and bit counter; accept and load never coincide
    // because accept needs an empty hold while load needs a full one
    always_ff @(posedge ck or posedge rst) begin
        if (rst) begin
            hold <= '0;
            hold_full <= 1'b0;
            sh <= '0;
            cnt <= '0;
        end else begin
            if (pv && pr) begin
                hold <= pi;
                hold_full <= 1'b1;
            end else if (load) begin
                hold_full <= 1'b0;
            end
            if (load) begin
                sh <= hold;
                cnt <= '0;
            end else if (adv) begin
                sh <= MSB_FIRST ? {sh[W-2:0], 1'b0} : {1'b0, sh[W-1:1]};
                cnt <= cnt + 1'b1;
            end
        end
    end

    // serial-side outputs and input handshake
    always_comb begin
        sv = state == SHIFT;
        so = sv ? (MSB_FIRST ? sh[W-1] : sh[0]) : IDLE_SO;
        sf = sv && cnt == '0;
        busy = sv || hold_full;
        pr = !hold_full && !rst;
    end
endmodule

// File: tb/tb_par_seri_buf.sv
// tb_par_seri_buf: three configurations of par_seri_buf checked against a word/bit-index model
module tb_par_seri_buf;
    logic ck = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b1;
    logic pv = 1'b0;
    logic [7:0] pi = '0;
    logic [2:0] pr_v, so_v, sv_v, sf_v, busy_v;

    int n_cmp = 0;
    int n_bad = 0;

    // model: configuration and per-instance state
    int mw[3] = '{4, 4, 8};
    bit mmsb[3] = '{1'b1, 1'b0, 1'b1};
    bit midl[3] = '{1'b0, 1'b1, 1'b0};
    logic [7:0] m_word[3], m_hold[3];
    int m_k[3];
    bit m_act[3], m_hf[3];

    // recorded serial streams
    logic [15:0] rec[3];
    int nsv[3], nsf[3];

    always #5 ck = ~ck;

    par_seri_buf #(.W(4), .MSB_FIRST(1'b1), .IDLE_SO(1'b0)) u0 (
        .ck(ck), .rst(rst), .en(en), .pv(pv), .pi(pi[3:0]),
        .pr(pr_v[0]), .so(so_v[0]), .sv(sv_v[0]), .sf(sf_v[0]), .busy(busy_v[0]));
    par_seri_buf #(.W(4), .MSB_FIRST(1'b0), .IDLE_SO(1'b1)) u1 (
        .ck(ck), .rst(rst), .en(en), .pv(pv), .pi(pi[3:0]),
        .pr(pr_v[1]), .so(so_v[1]), .sv(sv_v[1]), .sf(sf_v[1]), .busy(busy_v[1]));
    par_seri_buf #(.W(8), .MSB_FIRST(1'b1), .IDLE_SO(1'b0)) u2 (
        .ck(ck), .rst(rst), .en(en), .pv(pv), .pi(pi),
        .pr(pr_v[2]), .so(so_v[2]), .sv(sv_v[2]), .sf(sf_v[2]), .busy(busy_v[2]));

    task automatic chk(input string nm, input int i, input int a, input int e);
        n_cmp++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s[%0d] t=%0t got %0h want %0h", nm, i, $time, a, e);
        end
    endtask

    task automatic mreset();
        for (int i = 0; i < 3; i++) begin
            m_word[i] = '0;
            m_hold[i] = '0;
            m_k[i] = 0;
            m_act[i] = 1'b0;
            m_hf[i] = 1'b0;
        end
    endtask

    // one clock edge: a word is a list of W bits sent in order, bit k of the list
    // leaves on each en-qualified edge; the held word follows the last bit directly
    task automatic step();
        bit acc;
        if (rst) begin
            mreset();
            return;
        end
        for (int i = 0; i < 3; i++) begin
            acc = pv && !m_hf[i];
            if (m_act[i]) begin
                if (en) begin
                    m_k[i]++;
                    if (m_k[i] == mw[i]) begin
                        if (m_hf[i]) begin
                            m_word[i] = m_hold[i];
                            m_k[i] = 0;
                            m_hf[i] = 1'b0;
                        end else m_act[i] = 1'b0;
                    end
                end
            end else if (m_hf[i]) begin
                m_word[i] = m_hold[i];
                m_k[i] = 0;
                m_act[i] = 1'b1;
                m_hf[i] = 1'b0;
            end
            if (acc) begin
                m_hold[i] = mw[i] == 8 ? pi : {4'b0, pi[3:0]};
                m_hf[i] = 1'b1;
            end
        end
    endtask

    task automatic compare();
        logic e_so;
        for (int i = 0; i < 3; i++) begin
            e_so = m_act[i] ? m_word[i][mmsb[i] ? mw[i] - 1 - m_k[i] : m_k[i]] : midl[i];
            chk("so", i, int'(so_v[i]), int'(e_so));
            chk("sv", i, int'(sv_v[i]), int'(m_act[i]));
            chk("sf", i, int'(sf_v[i]), int'(m_act[i] && m_k[i] == 0));
            chk("pr", i, int'(pr_v[i]), int'(!m_hf[i] && !rst));
            chk("busy", i, int'(busy_v[i]), int'(m_act[i] || m_hf[i]));
            if (sv_v[i]) begin
                rec[i] = {rec[i][14:0], so_v[i]};
                nsv[i]++;
            end
            if (sf_v[i]) nsf[i]++;
        end
    endtask

    // model step on the rising edge, full compare on the falling edge
    initial begin
        mreset();
        for (int i = 0; i < 3; i++) begin
            rec[i] = '0;
            nsv[i] = 0;
            nsf[i] = 0;
        end
        forever begin
            @(posedge ck);
            step();
            @(negedge ck);
            if (rst) mreset();
            compare();
        end
    end

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    task automatic send0(input logic [7:0] d);
        bit ok = 1'b0;
        int t = 0;
        pi = d;
        pv = 1'b1;
        while (!ok && t < 50) begin
            ok = pr_v[0];
            tick();
            t++;
        end
        chk("send_accept", 0, int'(ok), 1);
    endtask

    int b_sv[3], b_sf[3];

    task automatic base();
        for (int i = 0; i < 3; i++) begin
            b_sv[i] = nsv[i];
            b_sf[i] = nsf[i];
        end
    endtask

    initial begin
        tick();
        chk("pr_in_reset", 0, int'(pr_v), 0);
        tick();
        rst = 1'b0;
        tick();
        chk("pr_after_reset", 0, int'(pr_v), 7);
        chk("so_idle", 0, int'(so_v), 3'b010);

        // single word, all three configurations
        base();
        pi = 8'h5d;
        pv = 1'b1;
        tick();
        pv = 1'b0;
        repeat (12) tick();
        chk("msb_word", 0, int'(rec[0][3:0]), 4'b1101);
        chk("lsb_word", 1, int'(rec[1][3:0]), 4'b1011);
        chk("w8_word", 2, int'(rec[2][7:0]), 8'h5d);
        chk("sv_cycles", 0, nsv[0] - b_sv[0], 4);
        chk("sf_cycles", 0, nsf[0] - b_sf[0], 1);
        chk("sv_cycles", 2, nsv[2] - b_sv[2], 8);
        chk("idle_after", 1, int'(so_v[1]), 1);

        // en toggling: every bit held for two cycles
        base();
        pi = 8'h0d;
        pv = 1'b1;
        tick();
        pv = 1'b0;
        for (int i = 0; i < 20; i++) begin
            en = (i >= 2) && (i % 2 == 0);
            tick();
        end
        en = 1'b1;
        repeat (12) tick();
        chk("en_msb", 0, int'(rec[0][7:0]), 8'b11110011);
        chk("en_lsb", 1, int'(rec[1][7:0]), 8'b11001111);
        chk("en_sv_cycles", 0, nsv[0] - b_sv[0], 8);
        chk("en_sf_cycles", 0, nsf[0] - b_sf[0], 2);

        // back-to-back words with pv held high
        base();
        send0(8'h0d);
        send0(8'h06);
        pv = 1'b0;
        repeat (24) tick();
        chk("b2b_stream", 0, int'(rec[0][7:0]), 8'b11010110);
        chk("b2b_sv_cycles", 0, nsv[0] - b_sv[0], 8);
        chk("b2b_sf_cycles", 0, nsf[0] - b_sf[0], 2);

        // reset mid-word with a second word held
        pi = 8'ha5;
        pv = 1'b1;
        tick();
        pi = 8'h3c;
        tick();
        tick();
        pv = 1'b0;
        tick();
        chk("held_pr", 2, int'(pr_v[2]), 0);
        chk("held_busy", 2, int'(busy_v[2]), 1);
        rst = 1'b1;
        #1;
        chk("rst_so", 2, int'(so_v), 3'b010);
        chk("rst_sv", 2, int'(sv_v), 0);
        chk("rst_sf", 2, int'(sf_v), 0);
        chk("rst_pr", 2, int'(pr_v), 0);
        chk("rst_busy", 2, int'(busy_v), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_pr", 2, int'(pr_v), 7);
        chk("post_rst_busy", 2, int'(busy_v), 0);
        base();
        repeat (12) tick();
        chk("no_residual", 2, nsv[2] - b_sv[2], 0);
        chk("no_residual", 0, nsv[0] - b_sv[0], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog t=%0t got timeout want finish", $time);
        $fatal(1, "watchdog");
    end
endmodule
